// File: rtl/cont_ctrl.sv
// Count sequencer: a WIDTH-bit up/down counter driven by an IDLE/RUN/PAUSE/DONE FSM.
// It counts against a limit captured at start, in one-shot or auto-reload mode.
module cont_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic                  clock,
  input  logic                  i_rs,
  input  logic                  i_start,
  input  logic                  i_pause,
  input  logic                  i_clear,
  input  logic [WIDTH-1:0]      i_limit,
  input  logic                  i_dir,
  input  logic                  i_reload,
  output logic [WIDTH-1:0]      o_count,
  output logic [WIDTH-1:0]      o_ncount,
  output logic [(1<<WIDTH)-1:0] o_onehot,
  output logic                  o_busy,
  output logic                  o_tc,
  output logic                  o_done,
  output logic [1:0]            o_state
);

  localparam int N = 1 << WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] start_val, end_val, start_in;

  // Captured values set the cycle; live inputs only matter at the moment of a start.
  assign start_val = dir_q ? limit_q : '0;
  assign end_val   = dir_q ? '0 : limit_q;
  assign start_in  = i_dir ? i_limit : '0;

  assign o_count  = count_q;
  assign o_ncount = ~count_q;
  assign o_onehot = N'(1) << count_q;
  assign o_busy   = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign o_tc     = (state_q == S_RUN) && (count_q == end_val);
  assign o_done   = done_q;
  assign o_state  = state_q;

  always_ff @(posedge clock or negedge i_rs) begin
    if (!i_rs) begin
      state_q <= S_IDLE;
      count_q <= '0;
      limit_q <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      limit_q <= limit_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    limit_d = limit_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    if (i_clear) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            limit_d = i_limit;
            dir_d   = i_dir;
            count_d = start_in;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          // The terminal compare precedes the step, so the counter never wraps.
          if (i_pause) begin
            state_d = S_PAUSE;
          end else if (o_tc) begin
            done_d = 1'b1;
            if (i_reload) count_d = start_val;
            else          state_d = S_DONE;
          end else begin
            count_d = dir_q ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
          end
        end
        S_PAUSE: begin
          if (!i_pause) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cont_ctrl.sv
// Bench for cont_ctrl: directed scenarios then random stimulus, compared each cycle
// against a behavioural model of the counting rules.
module tb_cont_ctrl;

  localparam int W = 3;

  logic           clock = 1'b0;
  logic           i_rs;
  logic           i_start, i_pause, i_clear, i_dir, i_reload;
  logic [W-1:0]   i_limit;
  logic [W-1:0]   o_count, o_ncount;
  logic [7:0]     o_onehot;
  logic           o_busy, o_tc, o_done;
  logic [1:0]     o_state;

  cont_ctrl #(.WIDTH(W)) dut (
    .clock(clock), .i_rs(i_rs), .i_start(i_start), .i_pause(i_pause),
    .i_clear(i_clear), .i_limit(i_limit), .i_dir(i_dir), .i_reload(i_reload),
    .o_count(o_count), .o_ncount(o_ncount), .o_onehot(o_onehot),
    .o_busy(o_busy), .o_tc(o_tc), .o_done(o_done), .o_state(o_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode is "idle", "run", "pause" or "done".
  string m_mode;
  int    m_cnt, m_lim, m_done;
  bit    m_down;

  function automatic int m_first();
    return m_down ? m_lim : 0;
  endfunction

  function automatic int m_last();
    return m_down ? 0 : m_lim;
  endfunction

  function automatic void model_reset();
    m_mode = "idle"; m_cnt = 0; m_lim = 0; m_down = 0; m_done = 0;
  endfunction

  function automatic void model_edge();
    m_done = 0;
    if (i_clear) begin
      m_mode = "idle";
      m_cnt  = 0;
    end else if (m_mode == "idle" || m_mode == "done") begin
      if (i_start) begin
        m_lim  = int'(i_limit);
        m_down = i_dir;
        m_cnt  = m_first();
        m_mode = "run";
      end
    end else if (m_mode == "pause") begin
      if (!i_pause) m_mode = "run";
    end else begin
      if (i_pause) m_mode = "pause";
      else if (m_cnt == m_last()) begin
        m_done = 1;
        if (i_reload) m_cnt = m_first();
        else          m_mode = "done";
      end else m_cnt = m_cnt + (m_down ? -1 : 1);
    end
  endfunction

  task automatic check_outputs();
    int busy, tc;
    busy = (m_mode == "run" || m_mode == "pause") ? 1 : 0;
    tc   = (m_mode == "run" && m_cnt == m_last()) ? 1 : 0;
    check("count",  32'(o_count),  32'(m_cnt));
    check("ncount", 32'(o_ncount), 32'(7 - m_cnt));
    check("onehot", 32'(o_onehot), 32'(2 ** m_cnt));
    check("busy",   32'(o_busy),   32'(busy));
    check("tc",     32'(o_tc),     32'(tc));
    check("done",   32'(o_done),   32'(m_done));
  endtask

  // driver: called at a falling edge; checks, drives, advances one cycle
  task automatic tick(input logic s, input logic p, input logic c,
                      input logic [W-1:0] l, input logic d, input logic r);
    check_outputs();
    i_start = s; i_pause = p; i_clear = c; i_limit = l; i_dir = d; i_reload = r;
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic idle_ticks(input int n, input logic r);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 3'd0, 0, r);
  endtask

  initial begin
    i_rs = 1'b0; i_start = 0; i_pause = 0; i_clear = 0; i_limit = 0; i_dir = 0; i_reload = 0;
    model_reset();
    repeat (2) @(negedge clock);
    i_rs = 1'b1;
    idle_ticks(3, 0);

    // up one-shot, limit 5, with an explicit expected count sequence
    tick(1, 0, 0, 3'd5, 0, 0);
    for (int v = 0; v <= 5; v++) exp_q.push_back(W'(v));
    exp_q.push_back(W'(5));
    while (exp_q.size() > 0) begin
      check("up_seq", 32'(o_count), 32'(exp_q.pop_front()));
      tick(0, 0, 0, 3'd0, 0, 0);
    end
    check("up_done_busy", 32'(o_busy), 32'(0));
    idle_ticks(2, 0);

    // down auto-reload, limit 3
    tick(1, 0, 0, 3'd3, 1, 1);
    idle_ticks(10, 1);
    tick(0, 0, 1, 3'd0, 0, 1);

    // pause at count 2 for 3 cycles, up, limit 6
    tick(1, 0, 0, 3'd6, 0, 0);
    idle_ticks(2, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 3'd0, 0, 0);
    check("pause_hold", 32'(o_count), 32'(2));
    idle_ticks(7, 0);

    // clear coincident with terminal count, limit 4
    tick(1, 0, 0, 3'd4, 0, 0);
    idle_ticks(4, 0);
    check("tc_before_clear", 32'(o_tc), 32'(1));
    tick(0, 0, 1, 3'd0, 0, 0);
    idle_ticks(1, 0);

    // limit 0 one-shot
    tick(1, 0, 0, 3'd0, 0, 0);
    check("lim0_tc", 32'(o_tc), 32'(1));
    idle_ticks(2, 0);

    // start ignored while running; then restart from done with limit 7
    tick(1, 0, 0, 3'd3, 0, 0);
    tick(1, 0, 0, 3'd6, 1, 0);
    idle_ticks(4, 0);
    tick(1, 0, 0, 3'd7, 0, 0);
    idle_ticks(10, 0);

    // asynchronous reset mid-count
    tick(1, 0, 0, 3'd6, 0, 0);
    idle_ticks(3, 0);
    #2 i_rs = 1'b0;
    #1;
    model_reset();
    check("rst_count",  32'(o_count),  32'(0));
    check("rst_ncount", 32'(o_ncount), 32'(3'b111));
    check("rst_onehot", 32'(o_onehot), 32'(8'h01));
    check("rst_busy",   32'(o_busy),   32'(0));
    @(negedge clock);
    i_rs = 1'b1;
    idle_ticks(3, 0);

    // random stimulus
    for (int i = 0; i < 2000; i++) begin
      logic s, p, c, d, r;
      logic [W-1:0] l;
      s = ($urandom_range(0, 3) == 0);
      p = (m_mode == "run" || m_mode == "pause") ? ($urandom_range(0, 3) == 0) : 1'b0;
      c = ($urandom_range(0, 31) == 0);
      d = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 2) == 0);
      l = W'($urandom_range(0, 7));
      tick(s, p, c, l, d, r);
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cont_ctrl.md
# cont_ctrl

Sequencing controller for the team's WIDTH-bit count datapath. It owns a synchronous counter and a four-state FSM that starts, pauses, clears and terminates counting against a programmable limit. It counts up or down, in one-shot or auto-reload mode, and presents the count in true, complemented and one-hot decoded form for the display and decode stages downstream.

## Interface
- WIDTH, 3, counter width in bits; one-hot output is 2**WIDTH bits.
- clock  in  1  single clock; all state changes on its rising edge.
- i_rs  in  1  asynchronous active-low reset.
- i_start  in  1  level, sampled each edge; begins a count from IDLE or DONE.
- i_pause  in  1  level; while high in RUN or PAUSE, the count holds.
- i_clear  in  1  synchronous clear to IDLE; highest priority after reset.
- i_limit  in  WIDTH  terminal value; captured into limit_q when a start is accepted.
- i_dir  in  1  0 = up, 1 = down; captured into dir_q when a start is accepted.
- i_reload  in  1  0 = one-shot, 1 = auto-reload; sampled live in RUN.
- o_count  out  WIDTH  current count.
- o_ncount  out  WIDTH  always ~o_count.
- o_onehot  out  2**WIDTH  always 1 << o_count.
- o_busy  out  1  high in RUN and PAUSE.
- o_tc  out  1  combinational; high when state is RUN and o_count equals the end value.
- o_done  out  1  registered one-cycle pulse when a count cycle completes.

## Operation
- Reset (i_rs low, asynchronous) sets these values: state IDLE, o_count 0, o_ncount all ones, o_onehot 1, o_busy 0, o_done 0, limit_q 0, dir_q 0.
- Start value and end value:
  - Up: start 0, end limit_q.
  - Down: start limit_q, end 0.
- Priority on each edge: i_clear, then i_pause, then i_start or counting.
- i_clear from any state: go to IDLE, o_count 0, o_done 0 on the next edge.
- IDLE:
  - i_start high: capture limit_q and dir_q, load o_count with the start value, go to RUN.
  - Otherwise hold.
- RUN:
  - i_pause high: go to PAUSE and hold the count.
  - Count not at end: step by 1 toward end.
  - Count at end (o_tc high), i_reload 1: load the start value, pulse o_done, stay in RUN.
  - Count at end, i_reload 0: go to DONE, hold the count, pulse o_done.
- PAUSE:
  - Count holds; o_busy stays 1; o_tc is 0.
  - i_pause low: return to RUN with no step taken on that edge.
- DONE:
  - o_busy 0; the count holds the end value.
  - i_start high: recapture limit_q and dir_q, load the start value, go to RUN.
- i_start is ignored in RUN and PAUSE.
- Changes to i_limit or i_dir after a start have no effect until the next start.
- Limit 0: the start value equals the end value, so o_tc is high in the first RUN cycle.
  - One-shot: DONE on the next edge.
  - Reload: o_done pulses every cycle.
- The counter never wraps modulo 2**WIDTH. The terminal compare always fires first, including limit = 2**WIDTH-1.

## Timing
- A start sampled at edge k gives: state RUN and o_count = start value after edge k; o_busy high from edge k.
- Up count, limit L: o_count = n after edge k+n. o_tc is high during the cycle after edge k+L. DONE and o_done high after edge k+L+1, for exactly one cycle.
- Down count from L: o_count = L-n after edge k+n; same terminal timing.
- A one-shot cycle takes L+1 RUN cycles. Auto-reload period is L+1 cycles.
- Pause asserted before edge j: o_count is frozen from edge j. Release before edge m: counting resumes at edge m+1.
- i_clear coincident with the terminal edge: the clear wins, o_done stays 0, state is IDLE.
- i_pause coincident with the terminal edge: the pause wins, state is PAUSE, and o_tc re-evaluates on resume.
- i_rs asserted mid-count: all outputs return to their reset values immediately, without waiting for a clock edge.

## Test plan
- Reset check: i_rs low while counting -> o_count 0, o_ncount 3'b111, o_onehot 8'h01, o_busy 0 immediately; after release, state stays IDLE with inputs idle.
- Up one-shot, WIDTH 3, limit 5: start pulse -> o_count 0,1,2,3,4,5 on successive edges, o_tc high at 5, then DONE with o_done high one cycle, o_busy 0, o_count held at 5.
- Down auto-reload, limit 3: -> o_count 3,2,1,0,3,2,...; o_done pulses once per 4 cycles; o_busy stays 1; o_onehot tracks 8'h08, 8'h04, 8'h02, 8'h01.
- Pause at count 2 for 3 cycles, up, limit 6 -> o_count held at 2 for 3 cycles, then 3 on the edge after release; o_busy 1 throughout.
- i_clear coincident with o_tc (limit 4) -> IDLE, o_count 0, no o_done pulse. Next, limit 0 one-shot -> o_tc high in the first RUN cycle, then DONE.
- i_start while RUN with a new i_limit -> ignored; the count completes against the original limit. A restart from DONE with limit 7 -> counts through 7, no wrap.
